// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin share of one 3-bit alu between two valid/ready requesters.
module alu (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  input  logic [2:0] op_i,
  output logic [3:0] res_o,
  output logic       carry_o,
  output logic       zero_o
);
  always_comb begin
    res_o = 4'd0;
    case (op_i)
      3'b000: res_o = {1'b0, a_i} + {1'b0, b_i};
      3'b001: res_o = {1'b0, a_i} - {1'b0, b_i};
      3'b010: res_o = {1'b0, a_i & b_i};
      3'b011: res_o = {1'b0, a_i | b_i};
      3'b100: res_o = {1'b0, a_i ^ b_i};
      3'b101: res_o = {1'b0, ~a_i};
      3'b110: res_o = {1'b0, ~(a_i & b_i)};
      default: res_o = {1'b0, ~(a_i | b_i)};
    endcase
    // bit 3 of a 4-bit add/sub is exactly carry/borrow for 3-bit operands
    carry_o = (op_i[2:1] == 2'b00) & res_o[3];
    zero_o = res_o == 4'd0;
  end
endmodule

module alu_req_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [5:0]       req_a,
  input  logic [5:0]       req_b,
  input  logic [5:0]       req_op,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [3:0]       rsp_res,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, owner_q, carry_q, zero_q, hs, alu_carry, alu_zero;
  logic [2:0] a_q, b_q, op_q;
  logic [3:0] res_q, alu_res;
  logic [1:0] grant;
  logic [CNT_W-1:0] cnt_q;
  alu u_alu (.a_i(a_q), .b_i(b_q), .op_i(op_q), .res_o(alu_res), .carry_o(alu_carry), .zero_o(alu_zero));
  always_comb begin
    grant[0] = req_valid[0] & (~req_valid[1] | last_q);
    grant[1] = req_valid[1] & (~req_valid[0] | ~last_q);
    req_ready = (state_q == IDLE && !rst) ? grant : 2'b00;
    rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    hs = (state_q == RESP) & rsp_ready[owner_q];
    state_d = (state_q == IDLE) ? (|grant ? EXEC : IDLE) :
              (state_q == EXEC) ? RESP : (hs ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      owner_q <= 1'b0;
      a_q <= 3'd0;
      b_q <= 3'd0;
      op_q <= 3'd0;
      res_q <= 4'd0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |grant) begin
        owner_q <= grant[1];
        a_q <= grant[1] ? req_a[5:3] : req_a[2:0];
        b_q <= grant[1] ? req_b[5:3] : req_b[2:0];
        op_q <= grant[1] ? req_op[5:3] : req_op[2:0];
      end
      if (state_q == EXEC) begin
        res_q <= alu_res;
        carry_q <= alu_carry;
        zero_q <= alu_zero;
      end
      if (hs) begin
        last_q <= owner_q;
        cnt_q <= cnt_q + CNT_W'(~&cnt_q);
      end
    end
  end
  assign rsp_res = res_q;
  assign rsp_carry = carry_q;
  assign rsp_zero = zero_q;
  assign busy = state_q != IDLE;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: transaction-level reference model with randomized traffic and directed scenarios.
module tb_alu_req_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = 2'b00, rsp_ready = 2'b00;
  logic [5:0] req_a = '0, req_b = '0, req_op = '0;
  logic [1:0] req_ready, rsp_valid, s_req_ready, s_rsp_valid;
  logic [3:0] rsp_res, s_rsp_res;
  logic rsp_carry, rsp_zero, busy, s_rsp_carry, s_rsp_zero, s_busy;
  logic [7:0] op_count;
  logic [1:0] s_op_count;
  int checks = 0, errors = 0;
  int m_last = 1, m_cnt = 0, m_sat = 0;

  alu_req_arbiter dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count));
  alu_req_arbiter #(.CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_op(req_op), .req_ready(s_req_ready), .rsp_valid(s_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_res(s_rsp_res), .rsp_carry(s_rsp_carry), .rsp_zero(s_rsp_zero),
    .busy(s_busy), .op_count(s_op_count));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // returns {carry, zero, res} from the opcode table using plain integer arithmetic
  function automatic logic [5:0] alu_ref(input int a, input int b, input int op);
    int r;
    logic c;
    logic [31:0] rv;
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 7); end
      1: begin r = (a - b + 16) % 16; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 7 - a;
      6: r = 7 - (a & b);
      default: r = 7 - (a | b);
    endcase
    rv = r;
    return {c, r == 0, rv[3:0]};
  endfunction

  task automatic run_op(input logic [1:0] v, input logic [2:0] a0, b0, o0, a1, b1, o1, input int hold);
    int w;
    logic [5:0] e;
    logic [1:0] er;
    req_valid = v;
    req_a = {a1, a0};
    req_b = {b1, b0};
    req_op = {o1, o0};
    rsp_ready = 2'($urandom);
    w = (v == 2'b11) ? 1 - m_last : (v == 2'b10 ? 1 : 0);
    er = (v == 2'b00) ? 2'b00 : (w == 1 ? 2'b10 : 2'b01);
    e = (w == 1) ? alu_ref(int'(a1), int'(b1), int'(o1)) : alu_ref(int'(a0), int'(b0), int'(o0));
    @(negedge clk);
    checks++; if (req_ready !== er) begin errors++; $display("FAIL idle_req_ready got %b exp %b", req_ready, er); end
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL idle_state busy %b rsp_valid %b exp 0 00", busy, rsp_valid); end
    checks++; if (op_count !== 8'(m_cnt)) begin errors++; $display("FAIL op_count got %0d exp %0d", op_count, m_cnt); end
    checks++; if (s_op_count !== 2'(m_sat)) begin errors++; $display("FAIL sat_op_count got %0d exp %0d", s_op_count, m_sat); end
    tick;
    if (v == 2'b00) return;
    req_a = 6'($urandom); req_b = 6'($urandom); req_op = 6'($urandom);
    req_valid = 2'($urandom); rsp_ready = 2'($urandom);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL exec_state busy %b req_ready %b rsp_valid %b exp 1 00 00", busy, req_ready, rsp_valid); end
    tick;
    for (int i = 0; i <= hold; i++) begin
      req_a = 6'($urandom); req_op = 6'($urandom);
      req_valid = 2'($urandom) | 2'b10;
      rsp_ready = 2'($urandom);
      rsp_ready[w] = (i == hold);
      @(negedge clk);
      checks++; if (rsp_valid !== er) begin errors++; $display("FAIL resp_valid got %b exp %b", rsp_valid, er); end
      checks++; if ({rsp_carry, rsp_zero, rsp_res} !== e) begin errors++; $display("FAIL resp_data carry,zero,res got %b exp %b", {rsp_carry, rsp_zero, rsp_res}, e); end
      checks++; if (busy !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL resp_state busy %b req_ready %b exp 1 00", busy, req_ready); end
      tick;
    end
    m_last = w;
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    m_sat = (m_sat < 3) ? m_sat + 1 : 3;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b11;
    tick;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if ({rsp_valid, rsp_res, rsp_carry, rsp_zero, busy, op_count} !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {rsp_valid, rsp_res, rsp_carry, rsp_zero, busy, op_count}); end
    rst = 1'b0;
    req_valid = 2'b00;
    m_last = 1; m_cnt = 0; m_sat = 0;
    tick;
  endtask

  task automatic test_single;
    run_op(2'b01, 3'd5, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 0);
    checks++; if ({rsp_res, rsp_carry, rsp_zero} !== 6'b1000_1_0) begin errors++; $display("FAIL r0_add got res %b c %b z %b exp 1000 1 0", rsp_res, rsp_carry, rsp_zero); end
    run_op(2'b10, 3'd0, 3'd0, 3'd0, 3'd3, 3'd5, 3'd1, 0);
    checks++; if ({rsp_res, rsp_carry, rsp_zero} !== 6'b1110_1_0) begin errors++; $display("FAIL r1_sub got res %b c %b z %b exp 1110 1 0", rsp_res, rsp_carry, rsp_zero); end
    run_op(2'b10, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd4, 0);
    checks++; if ({rsp_res, rsp_carry, rsp_zero} !== 6'b0000_0_1) begin errors++; $display("FAIL r1_xor got res %b c %b z %b exp 0000 0 1", rsp_res, rsp_carry, rsp_zero); end
  endtask

  task automatic test_fairness;
    for (int k = 0; k < 4; k++) run_op(2'b11, 3'd5, 3'd3, 3'd2, 3'd4, 3'd2, 3'd3, 0);
  endtask

  task automatic test_backpressure;
    run_op(2'b01, 3'd7, 3'd2, 3'd6, 3'd1, 3'd1, 3'd0, 5);
    run_op(2'b10, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 0);
  endtask

  task automatic test_drop;
    for (int k = 0; k < 3; k++) run_op(2'b00, 3'd1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd0, 0);
  endtask

  task automatic test_reset_mid(input int stage);
    req_valid = 2'b01; req_a = 6'd5; req_b = 6'd3; req_op = 6'd0; rsp_ready = 2'b00;
    tick;
    if (stage == 1) tick;
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midreset_req_ready got %b exp 00", req_ready); end
    tick;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_res, rsp_carry, rsp_zero, busy, op_count, s_op_count} !== '0) begin errors++; $display("FAIL midreset_outputs stage %0d got %h exp 0", stage, {rsp_valid, rsp_res, rsp_carry, rsp_zero, busy, op_count, s_op_count}); end
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    m_last = 1; m_cnt = 0; m_sat = 0;
    tick;
    run_op(2'b11, 3'd2, 3'd3, 3'd0, 3'd6, 3'd1, 3'd1, 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++)
      run_op(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             3'($urandom), int'($urandom_range(0, 3)));
    run_op(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_drop;
    test_reset_mid(0);
    test_reset_mid(1);
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
